// File: rtl/board_move_sequencer.sv
// Chess board store (64 x 4-bit) plus the sequencer that owns its single read and write port.
// Optional one-deep move undo is compiled in when BOARD_UNDO_EN is defined.
module board_move_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int PIECE_W = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               init_req,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [ADDR_W-1:0]  move_src,
    input  logic [ADDR_W-1:0]  move_dst,
    output logic               move_done,
    output logic               move_null,
    output logic [PIECE_W-1:0] captured_piece,
    output logic               capture_flag,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic [PIECE_W-1:0] disp_piece,
    output logic               disp_valid,
    output logic               busy,
    input  logic               undo_req,
    output logic               undo_avail
);

    localparam int SQUARES = 1 << ADDR_W;

    typedef enum logic [3:0] {
        INIT, IDLE, RD_SRC, RD_DST, WR_DST, CLR_SRC, DONE, UNDO_DST, UNDO_SRC
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0]    src_q, src_d, dst_q, dst_d;
    logic [PIECE_W-1:0]   src_piece_q, src_piece_d, dst_piece_q, dst_piece_d;
    logic [PIECE_W-1:0]   captured_piece_q, captured_piece_d;
    logic                 move_null_q, move_null_d;
    logic                 capture_flag_q, capture_flag_d;
    logic [PIECE_W-1:0]   disp_piece_q, disp_piece_d;
    logic                 disp_valid_q, disp_valid_d;

    logic [PIECE_W-1:0]   board_q [SQUARES];
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr, rd_addr;
    logic [PIECE_W-1:0]   wr_data, rd_data;
    logic                 disp_owner;

`ifdef BOARD_UNDO_EN
    logic [ADDR_W-1:0]    undo_src_q, undo_src_d, undo_dst_q, undo_dst_d;
    logic [PIECE_W-1:0]   undo_moved_q, undo_moved_d, undo_cap_q, undo_cap_d;
    logic                 undo_avail_q, undo_avail_d;
    assign undo_avail = undo_avail_q;
`else
    logic unused_undo;
    assign unused_undo = undo_req;
    assign undo_avail  = 1'b0;
`endif

    // Starting layout: row 0 is black's back rank, row 7 white's.
    function automatic logic [PIECE_W-1:0] init_piece(input logic [ADDR_W-1:0] a);
        logic [2:0] back;
        case (a[2:0])
            3'd0, 3'd7: back = 3'd4;
            3'd1, 3'd6: back = 3'd2;
            3'd2, 3'd5: back = 3'd3;
            3'd3:       back = 3'd5;
            default:    back = 3'd6;
        endcase
        case (a[5:3])
            3'd0:    init_piece = {1'b1, back};
            3'd1:    init_piece = 4'b1001;
            3'd6:    init_piece = 4'b0001;
            3'd7:    init_piece = {1'b0, back};
            default: init_piece = 4'b0000;
        endcase
    endfunction

    assign rd_addr        = (state_q == RD_SRC) ? src_q : (state_q == RD_DST) ? dst_q : disp_addr;
    assign rd_data        = board_q[rd_addr];
    assign move_ready     = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign move_done      = (state_q == DONE);
    assign move_null      = move_null_q;
    assign captured_piece = captured_piece_q;
    assign capture_flag   = capture_flag_q;
    assign disp_piece     = disp_piece_q;
    assign disp_valid     = disp_valid_q;

    always_comb begin
        disp_owner = (state_q == IDLE) || (state_q == WR_DST) || (state_q == CLR_SRC) ||
                     (state_q == DONE) || (state_q == UNDO_DST) || (state_q == UNDO_SRC);
    end

    always_comb begin
        state_d          = state_q;
        init_cnt_d       = init_cnt_q;
        src_d            = src_q;
        dst_d            = dst_q;
        src_piece_d      = src_piece_q;
        dst_piece_d      = dst_piece_q;
        captured_piece_d = captured_piece_q;
        move_null_d      = move_null_q;
        capture_flag_d   = capture_flag_q;
        wr_en            = 1'b0;
        wr_addr          = init_cnt_q;
        wr_data          = '0;
`ifdef BOARD_UNDO_EN
        undo_src_d       = undo_src_q;
        undo_dst_d       = undo_dst_q;
        undo_moved_d     = undo_moved_q;
        undo_cap_d       = undo_cap_q;
        undo_avail_d     = undo_avail_q;
`endif
        case (state_q)
            INIT: begin
                wr_en      = 1'b1;
                wr_addr    = init_cnt_q;
                wr_data    = init_piece(init_cnt_q);
                init_cnt_d = init_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef BOARD_UNDO_EN
                undo_avail_d = 1'b0;
`endif
                if (&init_cnt_q) state_d = IDLE;
            end
            IDLE: begin
                if (init_req) begin
                    state_d    = INIT;
                    init_cnt_d = '0;
`ifdef BOARD_UNDO_EN
                end else if (undo_req && undo_avail_q) begin
                    state_d = UNDO_DST;
`endif
                end else if (move_valid) begin
                    src_d   = move_src;
                    dst_d   = move_dst;
                    state_d = RD_SRC;
                end
            end
            RD_SRC: begin
                src_piece_d = rd_data;
                state_d     = RD_DST;
            end
            RD_DST: begin
                dst_piece_d = rd_data;
                if ((src_q == dst_q) || (src_piece_q[2:0] == 3'd0)) begin
                    move_null_d      = 1'b1;
                    captured_piece_d = rd_data;
                    capture_flag_d   = (rd_data[2:0] != 3'd0);
                    state_d          = DONE;
                end else begin
                    state_d = WR_DST;
                end
            end
            WR_DST: begin
                wr_en   = 1'b1;
                wr_addr = dst_q;
                wr_data = src_piece_q;
                state_d = CLR_SRC;
            end
            CLR_SRC: begin
                wr_en            = 1'b1;
                wr_addr          = src_q;
                wr_data          = '0;
                move_null_d      = 1'b0;
                captured_piece_d = dst_piece_q;
                capture_flag_d   = (dst_piece_q[2:0] != 3'd0);
`ifdef BOARD_UNDO_EN
                undo_src_d       = src_q;
                undo_dst_d       = dst_q;
                undo_moved_d     = src_piece_q;
                undo_cap_d       = dst_piece_q;
                undo_avail_d     = 1'b1;
`endif
                state_d          = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef BOARD_UNDO_EN
            UNDO_DST: begin
                wr_en   = 1'b1;
                wr_addr = undo_dst_q;
                wr_data = undo_cap_q;
                state_d = UNDO_SRC;
            end
            UNDO_SRC: begin
                wr_en        = 1'b1;
                wr_addr      = undo_src_q;
                wr_data      = undo_moved_q;
                move_null_d  = 1'b0;
                undo_avail_d = 1'b0;
                state_d      = DONE;
            end
`endif
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase

        // disp_valid marks a fresh display read; it is also forced low while heading into INIT.
        disp_piece_d = disp_owner ? rd_data : disp_piece_q;
        disp_valid_d = disp_owner && (state_d != INIT);
    end

    always_ff @(posedge CLK) begin
        if (wr_en) board_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q          <= INIT;
            init_cnt_q       <= '0;
            src_q            <= '0;
            dst_q            <= '0;
            src_piece_q      <= '0;
            dst_piece_q      <= '0;
            captured_piece_q <= '0;
            move_null_q      <= 1'b0;
            capture_flag_q   <= 1'b0;
            disp_piece_q     <= '0;
            disp_valid_q     <= 1'b0;
`ifdef BOARD_UNDO_EN
            undo_src_q       <= '0;
            undo_dst_q       <= '0;
            undo_moved_q     <= '0;
            undo_cap_q       <= '0;
            undo_avail_q     <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            init_cnt_q       <= init_cnt_d;
            src_q            <= src_d;
            dst_q            <= dst_d;
            src_piece_q      <= src_piece_d;
            dst_piece_q      <= dst_piece_d;
            captured_piece_q <= captured_piece_d;
            move_null_q      <= move_null_d;
            capture_flag_q   <= capture_flag_d;
            disp_piece_q     <= disp_piece_d;
            disp_valid_q     <= disp_valid_d;
`ifdef BOARD_UNDO_EN
            undo_src_q       <= undo_src_d;
            undo_dst_q       <= undo_dst_d;
            undo_moved_q     <= undo_moved_d;
            undo_cap_q       <= undo_cap_d;
            undo_avail_q     <= undo_avail_d;
`endif
        end
    end

endmodule
